// File: rtl/noc_probe_pkg.sv
// Shared flit layout, pattern byte, TX state encoding and header builder
// for the NoC flow probe.
package noc_probe_pkg;

  localparam int DEST_COL_LSB = 0;
  localparam int DEST_ROW_LSB = 8;
  localparam int SEQ_LSB      = 16;
  localparam int TS_LSB       = 32;
  localparam int PAY_LSB      = 48;

  localparam logic [7:0] PATTERN = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    WAIT,
    DONE
  } tx_state_e;

  // Header part only; payload bits above PAY_LSB are filled by the user.
  function automatic logic [PAY_LSB-1:0] make_flit(
    input logic [7:0]  row,
    input logic [7:0]  col,
    input logic [15:0] seq,
    input logic [15:0] ts
  );
    logic [PAY_LSB-1:0] f;
    f = '0;
    f[DEST_COL_LSB +: 8] = col;
    f[DEST_ROW_LSB +: 8] = row;
    f[SEQ_LSB +: 16]     = seq;
    f[TS_LSB +: 16]      = ts;
    return f;
  endfunction

endpackage

// File: rtl/noc_probe_checker.sv
// RX side of the flow probe: in-order sequence tracking, header check,
// sticky error flags and latency statistics.
module noc_probe_checker
  import noc_probe_pkg::*;
#(
  parameter int FLIT_W = 64,
  parameter int NF_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              busy,
  input  logic              timeout_hit,
  input  logic [NF_W-1:0]   num_flits,
  input  logic [7:0]        dest_row,
  input  logic [7:0]        dest_col,
  input  logic [15:0]       cyc,
  input  logic [FLIT_W-1:0] rx_flit,
  input  logic              rx_valid,
  output logic [NF_W-1:0]   recv_count,
  output logic [NF_W-1:0]   recv_next,
  output logic              err_hdr,
  output logic              err_seq,
  output logic              err_timeout,
  output logic [15:0]       lat_max,
  output logic [31:0]       lat_sum
);

  logic [15:0] exp_seq;
  logic [15:0] rx_seq;
  logic [15:0] rx_ts;
  logic [15:0] lat;
  logic        take;
  logic        hdr_bad;
  logic [32:0] sum_w;

  assign rx_seq    = rx_flit[SEQ_LSB +: 16];
  assign rx_ts     = rx_flit[TS_LSB +: 16];
  assign lat       = cyc - rx_ts;
  assign take      = rx_valid && busy && (recv_count != num_flits);
  assign recv_next = take ? recv_count + NF_W'(1) : recv_count;
  assign sum_w     = {1'b0, lat_sum} + 33'(lat);

  always_comb begin
    hdr_bad = (rx_flit[DEST_COL_LSB +: 8] != dest_col) ||
              (rx_flit[DEST_ROW_LSB +: 8] != dest_row);
    for (int i = PAY_LSB; i < FLIT_W; i++)
      if (rx_flit[i] != PATTERN[3'((i - PAY_LSB) % 8)])
        hdr_bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recv_count  <= '0;
      exp_seq     <= '0;
      err_hdr     <= 1'b0;
      err_seq     <= 1'b0;
      err_timeout <= 1'b0;
      lat_max     <= '0;
      lat_sum     <= '0;
    end else if (clear) begin
      recv_count  <= '0;
      exp_seq     <= '0;
      err_hdr     <= 1'b0;
      err_seq     <= 1'b0;
      err_timeout <= 1'b0;
      lat_max     <= '0;
      lat_sum     <= '0;
    end else begin
      if (timeout_hit)
        err_timeout <= 1'b1;
      // Stray flit: idle probe or more flits than were sent.
      if (rx_valid && !take)
        err_seq <= 1'b1;
      if (take) begin
        recv_count <= recv_next;
        if (hdr_bad)
          err_hdr <= 1'b1;
        if (rx_seq != exp_seq)
          err_seq <= 1'b1;
        exp_seq <= rx_seq + 16'd1;
        if (lat > lat_max)
          lat_max <= lat;
        lat_sum <= sum_w[32] ? '1 : sum_w[31:0];
      end
    end
  end

endmodule

// File: rtl/noc_flow_probe.sv
// Burst injector for one mesh injection port with an in-order delivery
// checker on one ejection port.
module noc_flow_probe
  import noc_probe_pkg::*;
#(
  parameter int FLIT_W    = 64,
  parameter int MAX_FLITS = 256,
  parameter int GAP_W     = 8,
  parameter int TIMEOUT   = 1024,
  parameter int NF_W      = $clog2(MAX_FLITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        cfg_dest_row,
  input  logic [7:0]        cfg_dest_col,
  input  logic [NF_W-1:0]   cfg_num_flits,
  input  logic [GAP_W-1:0]  cfg_gap,
  output logic [FLIT_W-1:0] tx_flit,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [FLIT_W-1:0] rx_flit,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              err_hdr,
  output logic              err_seq,
  output logic              err_timeout,
  output logic [NF_W-1:0]   sent_count,
  output logic [NF_W-1:0]   recv_count,
  output logic [15:0]       lat_max,
  output logic [31:0]       lat_sum
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  tx_state_e         state, state_d;
  logic [15:0]       cyc;
  logic [NF_W-1:0]   num_q;
  logic [NF_W-1:0]   recv_next;
  logic [NF_W-1:0]   seq_n;
  logic [7:0]        row_q, col_q;
  logic [7:0]        ld_row, ld_col;
  logic [GAP_W-1:0]  gap_q, gap_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [FLIT_W-1:0] flit_d;
  logic launch, tx_hs, rx_hs, last_tx;
  logic rx_all, timeout_hit, load;

  assign rx_ready    = 1'b1;
  assign busy        = state inside {SEND, GAP, WAIT};
  assign done        = state == DONE;
  assign tx_valid    = state == SEND;
  assign pass        = done && !(err_hdr || err_seq || err_timeout);
  assign launch      = start && !busy;
  assign tx_hs       = tx_valid && tx_ready;
  assign rx_hs       = rx_valid;
  assign last_tx     = sent_count == num_q - NF_W'(1);
  assign rx_all      = recv_next == num_q;
  assign timeout_hit = busy && !tx_hs && !rx_hs &&
                       (to_cnt == TO_W'(TIMEOUT - 1));

  assign ld_row = launch ? cfg_dest_row : row_q;
  assign ld_col = launch ? cfg_dest_col : col_q;
  assign seq_n  = launch ? '0 :
                  tx_hs  ? sent_count + NF_W'(1) : sent_count;

  // Stamp with the cycle in which the flit is first presented.
  always_comb begin
    flit_d = '0;
    flit_d[PAY_LSB-1:0] = make_flit(ld_row, ld_col, 16'(seq_n),
                                    cyc + 16'd1);
    for (int i = PAY_LSB; i < FLIT_W; i++)
      flit_d[i] = PATTERN[3'((i - PAY_LSB) % 8)];
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = (cfg_num_flits == '0) ? DONE : SEND;
          load    = cfg_num_flits != '0;
        end
      end
      SEND: begin
        if (tx_hs) begin
          if (last_tx)
            state_d = rx_all ? DONE : WAIT;
          else if (gap_q != '0)
            state_d = GAP;
          else
            load = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      WAIT: begin
        if (rx_all)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      state_d = DONE;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc        <= '0;
      num_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      sent_count <= '0;
      tx_flit    <= '0;
    end else begin
      state <= state_d;
      cyc   <= cyc + 16'd1;
      if (launch) begin
        num_q      <= cfg_num_flits;
        row_q      <= cfg_dest_row;
        col_q      <= cfg_dest_col;
        gap_q      <= cfg_gap;
        sent_count <= '0;
      end else if (tx_hs) begin
        sent_count <= sent_count + NF_W'(1);
      end
      if (load)
        tx_flit <= flit_d;
      if (tx_hs)
        gap_cnt <= gap_q - GAP_W'(1);
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - GAP_W'(1);
      if (launch || tx_hs || rx_hs || !busy)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TO_W'(1);
    end
  end

  noc_probe_checker #(
    .FLIT_W (FLIT_W),
    .NF_W   (NF_W)
  ) u_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (launch),
    .busy        (busy),
    .timeout_hit (timeout_hit),
    .num_flits   (num_q),
    .dest_row    (row_q),
    .dest_col    (col_q),
    .cyc         (cyc),
    .rx_flit     (rx_flit),
    .rx_valid    (rx_valid),
    .recv_count  (recv_count),
    .recv_next   (recv_next),
    .err_hdr     (err_hdr),
    .err_seq     (err_seq),
    .err_timeout (err_timeout),
    .lat_max     (lat_max),
    .lat_sum     (lat_sum)
  );

endmodule

// File: tb/tb_noc_flow_probe.sv
// Directed bench: probe tx looped to rx through a 2-register pipe that can
// swap, corrupt or drop flits.
module tb_noc_flow_probe;

  localparam int FW = 64;
  localparam int MF = 256;
  localparam int GW = 8;
  localparam int TO = 64;
  localparam int NW = $clog2(MF + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    cfg_dest_row = '0;
  logic [7:0]    cfg_dest_col = '0;
  logic [NW-1:0] cfg_num_flits = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic          tx_ready = 1'b1;
  logic [FW-1:0] tx_flit, rx_flit;
  logic          tx_valid, rx_valid, rx_ready;
  logic          busy, done, pass;
  logic          err_hdr, err_seq, err_timeout;
  logic [NW-1:0] sent_count, recv_count;
  logic [15:0]   lat_max;
  logic [31:0]   lat_sum;

  int checks = 0;
  int errors = 0;
  int mode = 0;

  logic [FW-1:0] cap, p1, p2;
  logic          cap_ok, v1, v2;

  always #5 clk = ~clk;

  noc_flow_probe #(
    .FLIT_W    (FW),
    .MAX_FLITS (MF),
    .GAP_W     (GW),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_dest_row  (cfg_dest_row),
    .cfg_dest_col  (cfg_dest_col),
    .cfg_num_flits (cfg_num_flits),
    .cfg_gap       (cfg_gap),
    .tx_flit       (tx_flit),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_flit       (rx_flit),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_hdr       (err_hdr),
    .err_seq       (err_seq),
    .err_timeout   (err_timeout),
    .sent_count    (sent_count),
    .recv_count    (recv_count),
    .lat_max       (lat_max),
    .lat_sum       (lat_sum)
  );

  // mode 1: swap seq 1/2, 2: corrupt col of seq 0, 3: drop seq 3
  always_comb begin
    cap    = tx_flit;
    cap_ok = tx_valid && tx_ready;
    case (mode)
      1: begin
        if (tx_flit[31:16] == 16'd1) cap[31:16] = 16'd2;
        else if (tx_flit[31:16] == 16'd2) cap[31:16] = 16'd1;
      end
      2: if (tx_flit[31:16] == 16'd0) cap[7:0] = 8'd2;
      3: if (tx_flit[31:16] == 16'd3) cap_ok = 1'b0;
      default: ;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      p1 <= '0;
      p2 <= '0;
    end else begin
      v1 <= cap_ok;
      p1 <= cap;
      v2 <= v1;
      p2 <= p1;
    end
  end

  assign rx_valid = v2;
  assign rx_flit  = p2;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n, input int gap);
    @(negedge clk);
    cfg_dest_row  = 8'd1;
    cfg_dest_col  = 8'd1;
    cfg_num_flits = NW'(n);
    cfg_gap       = GW'(gap);
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !done; i++)
      @(negedge clk);
    check("done", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] f;
    int nrx;
    int k;
    int t;

    repeat (2) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    rst_n = 1'b1;

    // back-to-back burst of 4, latency 2 each
    mode = 0;
    tx_ready = 1'b1;
    run(4, 0);
    check("t1_hdr", 32'(tx_flit[15:0]), 32'h0101);
    check("t1_pay", 32'(tx_flit[63:48]), 32'hA5A5);
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", 32'(tx_valid), 32'd1);
      check("t1_seq", 32'(tx_flit[31:16]), i);
      @(negedge clk);
    end
    wait_done(50);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_recv", 32'(recv_count), 32'd4);
    check("t1_sent", 32'(sent_count), 32'd4);
    check("t1_lat_max", 32'(lat_max), 32'd2);
    check("t1_lat_sum", lat_sum, 32'd8);

    // ready toggling: flit must hold through each stall
    tx_ready = 1'b0;
    run(3, 0);
    for (int i = 0; i < 3; i++) begin
      tx_ready = 1'b0;
      check("t2_seq", 32'(tx_flit[31:16]), i);
      f = tx_flit;
      @(negedge clk);
      check("t2_stable", 32'(tx_flit == f && tx_valid), 32'd1);
      tx_ready = 1'b1;
      @(negedge clk);
    end
    tx_ready = 1'b1;
    wait_done(50);
    check("t2_pass", 32'(pass), 32'd1);
    check("t2_sent", 32'(sent_count), 32'd3);

    // gap of 3: valid at +1, +5, +9 after start
    run(3, 3);
    for (int j = 1; j < 12; j++) begin
      check("t3_valid", 32'(tx_valid), 32'(j == 1 || j == 5 || j == 9));
      @(negedge clk);
    end
    wait_done(50);
    check("t3_pass", 32'(pass), 32'd1);

    // out-of-order delivery
    mode = 1;
    run(4, 0);
    wait_done(50);
    check("t4_err_seq", 32'(err_seq), 32'd1);
    check("t4_err_hdr", 32'(err_hdr), 32'd0);
    check("t4_pass", 32'(pass), 32'd0);
    check("t4_recv", 32'(recv_count), 32'd4);

    // corrupted destination column
    mode = 2;
    run(4, 0);
    wait_done(50);
    check("t4b_err_hdr", 32'(err_hdr), 32'd1);
    check("t4b_err_seq", 32'(err_seq), 32'd0);
    check("t4b_pass", 32'(pass), 32'd0);

    // last flit lost: timeout TO edges after the third receive
    mode = 3;
    run(4, 0);
    nrx = 0;
    k = 0;
    while (nrx < 3 && k < 50) begin
      @(negedge clk);
      k++;
      if (rx_valid) nrx++;
    end
    check("t5_rx3", nrx, 32'd3);
    @(posedge clk);
    t = 0;
    while (!err_timeout && t < 200) begin
      @(posedge clk);
      t++;
      #1;
    end
    check("t5_to_lat", t, TO);
    @(negedge clk);
    check("t5_done", 32'(done), 32'd1);
    check("t5_err_to", 32'(err_timeout), 32'd1);
    check("t5_recv", 32'(recv_count), 32'd3);
    check("t5_sent", 32'(sent_count), 32'd4);
    check("t5_pass", 32'(pass), 32'd0);

    // empty burst
    mode = 0;
    run(0, 0);
    check("t6_done", 32'(done), 32'd1);
    check("t6_pass", 32'(pass), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_sent", 32'(sent_count), 32'd0);

    // reset mid-burst
    run(8, 0);
    @(negedge clk);
    @(negedge clk);
    check("t7_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t7_tx_valid", 32'(tx_valid), 32'd0);
    check("t7_rx_ready", 32'(rx_ready), 32'd1);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_done", 32'(done), 32'd0);
    check("t7_sent", 32'(sent_count), 32'd0);
    check("t7_recv", 32'(recv_count), 32'd0);
    check("t7_lat_sum", lat_sum, 32'd0);
    check("t7_lat_max", 32'(lat_max), 32'd0);
    check("t7_flit", 32'(tx_flit[31:0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_idle_valid", 32'(tx_valid), 32'd0);
    check("t7_idle_err", 32'(err_seq), 32'd0);

    run(2, 0);
    wait_done(50);
    check("t8_pass", 32'(pass), 32'd1);
    check("t8_recv", 32'(recv_count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_flow_probe.md
# noc_flow_probe

Parametrised traffic injector and in-order delivery checker for the router mesh. It attaches to one injection port (usually the host ext port) and one ejection port (a tile local port). On each run it streams a programmable burst of sequence-numbered, timestamped flits to a configured (row, col) and checks that every flit arrives in order with the correct header. It reports per-run latency statistics and pass/fail. It generalises single-flit host injection to N flits with gap control, timeout, and sequence/latency checking.

## Interface
- FLIT_W, 64, flit width; must be ≥ 48.
- MAX_FLITS, 256, largest burst per run.
- GAP_W, 8, width of inter-flit gap config.
- TIMEOUT, 1024, cycles without tx or rx progress before the run aborts.
- NF_W, $clog2(MAX_FLITS+1), width of flit counts.
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; latches config and begins a run. Ignored while busy.
- cfg_dest_row  in  8  destination row.
- cfg_dest_col  in  8  destination column.
- cfg_num_flits  in  NF_W  burst length, 0..MAX_FLITS.
- cfg_gap  in  GAP_W  idle cycles inserted after each tx handshake.
- tx_flit  out  FLIT_W  injected flit.
- tx_valid  out  1  injection valid.
- tx_ready  in  1  mesh accepts flit.
- rx_flit  in  FLIT_W  ejected flit.
- rx_valid  in  1  ejection valid.
- rx_ready  out  1  always 1 out of reset.
- busy  out  1  run in progress.
- done  out  1  run finished; level, held until next start.
- pass  out  1  done and no error flags set.
- err_hdr, err_seq, err_timeout  out  1 each  sticky error flags.
- sent_count, recv_count  out  NF_W each  handshakes completed this run.
- lat_max  out  16  worst latency this run, in cycles.
- lat_sum  out  32  latency sum, saturating.

## Operation
- Flit format: [7:0] dest_col, [15:8] dest_row, [31:16] seq, [47:32] tx timestamp, [FLIT_W-1:48] repeated 0xA5.
- Free-running 16-bit cycle counter runs from reset and wraps.
- TX FSM states: IDLE, SEND, GAP, WAIT, DONE.
  - IDLE --start--> SEND. If cfg_num_flits == 0, go to DONE instead.
  - SEND: tx_valid=1. On handshake, increment seq. If seq == N-1, go to WAIT. Else if gap > 0, go to GAP. Else stay in SEND.
  - GAP: count cfg_gap cycles, then return to SEND.
  - WAIT: when recv_count == N, go to DONE.
  - Any state except IDLE/DONE: if the timeout counter reaches TIMEOUT, set err_timeout and go to DONE.
  - DONE --start--> SEND or DONE, with counters and flags cleared.
- Timestamp is stamped when the flit is loaded into the tx register. It must stay stable while tx_valid && !tx_ready.
- The timeout counter clears on any tx or rx handshake and on start.
- RX checker, active while busy:
  - Header mismatch sets err_hdr.
  - seq ≠ expected sets err_seq; expected is then resynced to seq+1.
  - A flit arriving when recv_count == N sets err_seq.
  - A flit arriving while not busy sets err_seq and is otherwise dropped.
- Latency = (cycle_counter − timestamp) mod 2^16, measured on the rx handshake cycle.

## Timing
- Reset values: all outputs 0 except rx_ready=1. FSM is in IDLE, counters are 0.
- tx_valid rises the cycle after the start pulse. With gap=0 and tx_ready=1, one flit per cycle.
- With gap=G: tx_valid is low for exactly G cycles after each handshake.
- done and busy change one cycle after the terminating event: the last rx handshake, or timeout expiry. num=0: done=1 one cycle after start.
- On an rx handshake in the same cycle as timeout expiry, the rx handshake wins and the timeout counter clears.
- rst_n low mid-run: immediate return to reset values; no partial flit is held.

## Structure
- Package noc_probe_pkg holds:
  - field offset localparams: DEST_COL_LSB=0, DEST_ROW_LSB=8, SEQ_LSB=16, TS_LSB=32, PAY_LSB=48;
  - the PATTERN byte 8'hA5;
  - the tx_state_e enum;
  - function make_flit(row, col, seq, ts).
- One sub-module: noc_probe_checker. It contains the rx expected-seq tracking, error flags, latency max/sum, and recv_count. The top holds the TX FSM, gap and timeout counters, and the cycle counter.

## Test plan
- N=4, gap=0, tx looped to rx through a 2-cycle register pipe, tx_ready=1 -> seq 0..3 on consecutive cycles; done, pass=1, recv_count=4, lat_max=2, lat_sum=8.
- N=3, tx_ready toggling 0,1,0,1 -> tx_flit stable during stall; seq 0,1,2; pass=1, sent_count=3.
- N=3, gap=3 -> tx_valid rises at cycles +1, +5, +9 after start.
- N=4, pipe swaps flits 1 and 2 -> err_seq=1, pass=0, recv_count=4; header corrupted to col=2 -> err_hdr=1.
- N=4, TIMEOUT=64, pipe drops the last flit -> err_timeout=1 64 cycles after the third receive; done=1, recv_count=3.
- N=0 -> done=1, pass=1 the next cycle. Separately, rst_n pulsed mid-burst -> all outputs return to reset values, tx_valid=0 and rx_ready=1 while rst_n is low.
- Integration: inject through router_mesh 2×2 host to tile (1,1), N=8 -> pass=1, lat_max ≤ 10.
